// File: rtl/dense_acc_requant_pkg.sv
// Shared types and constants for the dense-layer accumulate/requantise block.
package dense_acc_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, HOLD} state_e;

  // Half-LSB of the output grid, added before the arithmetic shift.
  function automatic longint round_const(input int frac_shift);
    return 64'sd1 <<< (frac_shift - 1);
  endfunction

  function automatic longint sat_max(input int out_w);
    return (64'sd1 <<< (out_w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int out_w);
    return -(64'sd1 <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/dense_acc_requant_if.sv
// Product stream in, requantised result out; both valid/ready.
interface dense_acc_requant_if #(
  parameter int PROD_W = 22,
  parameter int OUT_W  = 16
);
  logic              prod_valid;
  logic [PROD_W-1:0] prod_data;
  logic              prod_last;
  logic [OUT_W-1:0]  bias;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_sat;

  modport master (
    output prod_valid, prod_data, prod_last, bias, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  prod_valid, prod_data, prod_last, bias, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/dense_acc_requant_sat_relu.sv
// Round half up, arithmetic shift, saturate to OUT_W, optional ReLU.
module dense_acc_sat_relu
  import dense_acc_pkg::*;
#(
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 6,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] data,
  output logic                    sat
);
  // One extra bit so the rounding add cannot wrap near the accumulator top.
  localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(round_const(FRAC_SHIFT));
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(sat_max(OUT_W));
  localparam logic signed [ACC_W:0] MINV = (ACC_W+1)'(sat_min(OUT_W));

  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] r;

  always_comb begin
    sum  = $signed({acc[ACC_W-1], acc}) + RND;
    r    = sum >>> FRAC_SHIFT;
    data = r[OUT_W-1:0];
    sat  = 1'b0;
    if (r > MAXV) begin
      data = OUT_W'(sat_max(OUT_W));
      sat  = 1'b1;
    end else if (r < MINV) begin
      data = OUT_W'(sat_min(OUT_W));
      sat  = 1'b1;
    end
    if (RELU_EN && (r < 0)) data = '0;
  end
endmodule

// File: rtl/dense_acc_requant.sv
// Bias-seeded product accumulator; emits one requantised result per vector.
module dense_acc_requant
  import dense_acc_pkg::*;
#(
  parameter int PROD_W     = 22,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 6,
  parameter bit RELU_EN    = 1'b1
) (
  input logic               clk,
  input logic               reset,
  input logic               ce,
  dense_acc_requant_if.slave s
);
  state_e                   state, state_nx;
  logic signed [ACC_W-1:0]  acc, acc_nx;
  logic signed [ACC_W-1:0]  prod_ext, bias_sh;
  logic signed [OUT_W-1:0]  out_data, rq_data;
  logic                     out_sat, rq_sat;
  logic                     in_ready, out_valid, accept;

  assign prod_ext = ACC_W'($signed(s.prod_data));
  assign bias_sh  = ACC_W'($signed(s.bias)) <<< FRAC_SHIFT;

  dense_acc_sat_relu #(
    .ACC_W(ACC_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT), .RELU_EN(RELU_EN)
  ) u_sat (
    .acc (acc),
    .data(rq_data),
    .sat (rq_sat)
  );

  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        accept   = ce && s.prod_valid;
        if (accept) begin
          acc_nx   = (state == IDLE) ? bias_sh + prod_ext : acc + prod_ext;
          state_nx = s.prod_last ? FINAL : ACCUM;
        end
      end
      FINAL: state_nx = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (ce && s.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Reset wins over ce; ce gates every register including the result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (ce) begin
      state <= state_nx;
      if (accept) acc <= acc_nx;
      if (state == FINAL) begin
        out_data <= rq_data;
        out_sat  <= rq_sat;
      end
    end
  end

  assign s.in_ready  = in_ready;
  assign s.out_valid = out_valid;
  assign s.out_data  = out_data;
  assign s.out_sat   = out_sat;
endmodule

// File: tb/tb_dense_acc_requant.sv
// Directed checks on a ReLU and a linear instance driven with identical stimulus.
module tb_dense_acc_requant;
  logic clk = 1'b0;
  logic reset, ce, out_ready, prod_valid, prod_last;
  logic signed [21:0] prod_data;
  logic [15:0] bias;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dense_acc_requant_if #(.PROD_W(22), .OUT_W(16)) ifr ();
  dense_acc_requant_if #(.PROD_W(22), .OUT_W(16)) ifl ();

  assign ifr.prod_valid = prod_valid;
  assign ifr.prod_data  = prod_data;
  assign ifr.prod_last  = prod_last;
  assign ifr.bias       = bias;
  assign ifr.out_ready  = out_ready;
  assign ifl.prod_valid = prod_valid;
  assign ifl.prod_data  = prod_data;
  assign ifl.prod_last  = prod_last;
  assign ifl.bias       = bias;
  assign ifl.out_ready  = out_ready;

  dense_acc_requant #(.RELU_EN(1'b1)) u_relu (.clk(clk), .reset(reset), .ce(ce), .s(ifr.slave));
  dense_acc_requant #(.RELU_EN(1'b0)) u_lin  (.clk(clk), .reset(reset), .ce(ce), .s(ifl.slave));

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int d, input bit last);
    prod_valid = 1'b1;
    prod_data  = 22'(d);
    prod_last  = last;
    tick();
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  // Waits (bounded) for out_valid; ends on the negedge where it was seen.
  task automatic get_result(output longint dr, output longint dl,
                            output bit sr, output bit sl, output int lat);
    lat = 0; dr = 0; dl = 0; sr = 0; sl = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ifr.out_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) chk("result_timeout", 0, 1);
    dr = longint'($signed(ifr.out_data));
    dl = longint'($signed(ifl.out_data));
    sr = ifr.out_sat;
    sl = ifl.out_sat;
  endtask

  task automatic expect_res(input string tag, input longint er, input longint el,
                            input bit es, input bit handshake);
    longint dr, dl;
    bit sr, sl;
    int lat;
    get_result(dr, dl, sr, sl, lat);
    chk({tag, "_relu_data"}, dr, er);
    chk({tag, "_lin_data"}, dl, el);
    chk({tag, "_relu_sat"}, longint'(sr), longint'(es));
    chk({tag, "_lin_sat"}, longint'(sl), longint'(es));
    if (handshake) tick();
  endtask

  initial begin
    longint dr, dl;
    bit sr, sl;
    int lat;
    reset = 1'b0; ce = 1'b1; out_ready = 1'b1;
    prod_valid = 1'b0; prod_last = 1'b0; prod_data = '0; bias = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", longint'(ifr.out_valid), 0);
    chk("rst_out_data", longint'(ifr.out_data), 0);
    chk("rst_out_sat", longint'(ifl.out_sat), 0);
    chk("rst_in_ready", longint'(ifl.in_ready), 1);
    @(posedge clk); #1;
    reset = 1'b1;

    // three-beat vector, latency check
    bias = 16'd0;
    beat(64, 0); beat(128, 0); beat(192, 1);
    get_result(dr, dl, sr, sl, lat);
    chk("t1_latency", lat, 2);
    chk("t1_relu_data", dr, 6);
    chk("t1_lin_data", dl, 6);
    chk("t1_sat", longint'(sr), 0);
    tick();

    // rounding at the half-LSB boundary
    beat(32, 1);  expect_res("t2_half", 1, 1, 0, 1);
    beat(31, 1);  expect_res("t2_below", 0, 0, 0, 1);
    beat(-32, 1); expect_res("t2_neg_half", 0, 0, 0, 1);

    // negative bias: ReLU clamps, linear rounds half up toward -10
    bias = -16'sd5;
    beat(-320, 1); expect_res("t3_negbias", 0, -10, 0, 1);
    bias = 16'd0;

    // saturation both ways
    beat(2097151, 0); beat(2097151, 0); beat(2097151, 1);
    expect_res("t4_pos_sat", 32767, 32767, 1, 1);
    beat(-2097152, 0); beat(-2097152, 0); beat(-2097152, 1);
    expect_res("t4_neg_sat", 0, -32768, 1, 1);

    // backpressure: result held, pending beat not consumed
    out_ready = 1'b0;
    beat(64, 1);
    get_result(dr, dl, sr, sl, lat);
    chk("t5_first", dr, 1);
    prod_valid = 1'b1; prod_data = 22'sd640; prod_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold_data", longint'($signed(ifr.out_data)), 1);
      chk("t5_hold_valid", longint'(ifl.out_valid), 1);
      chk("t5_in_ready", longint'(ifr.in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t5_released", longint'(ifr.out_valid), 0);
    chk("t5_ready_again", longint'(ifr.in_ready), 1);
    tick();
    prod_valid = 1'b0; prod_last = 1'b0;
    expect_res("t5_next", 10, 10, 0, 1);

    // reset mid-vector discards the partial sum
    beat(100, 0); beat(200, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", longint'(ifr.out_valid), 0);
    chk("t6_rst_data", longint'(ifl.out_data), 0);
    chk("t6_rst_ready", longint'(ifl.in_ready), 1);
    bias = 16'd1;
    tick();
    beat(0, 1); expect_res("t6_fresh", 1, 1, 0, 1);
    bias = 16'd0;

    // ce low mid-vector with a poison beat presented
    beat(64, 0);
    ce = 1'b0;
    prod_valid = 1'b1; prod_data = 22'sd999; prod_last = 1'b1;
    repeat (3) tick();
    prod_valid = 1'b0; prod_last = 1'b0;
    ce = 1'b1;
    beat(128, 0); beat(192, 1);
    expect_res("t6_ce_gap", 6, 6, 0, 0);
    ce = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_ce_hold_valid", longint'(ifr.out_valid), 1);
    ce = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_ce_release", longint'(ifr.out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
